reg_file: RTL and testbench
===========================

Name: reg_file

Overview:
Integer register file for the single-cycle RV32I core. It sits directly upstream of the ALU: read data 1 drives ALU in1, and read data 2 drives ALU in2 (or the immediate mux). It provides two combinational read ports and one synchronous write port, with x0 hardwired to zero. The write port is fed from the writeback mux (ALU result, load data, or PC+4).

Parameters:
WORDSIZE, 32, data width of each register and of all data ports.
REGNUM, 32, number of architectural registers; must be a power of two.
ADDRW, 5, register index width; must equal log2(REGNUM).

Ports:
clk  input  1  core clock; all state updates on rising edge.
rst  input  1  asynchronous, active-high reset.
rs1  input  ADDRW  read port 1 index (instr[19:15]).
rs2  input  ADDRW  read port 2 index (instr[24:20]).
rd  input  ADDRW  write index (instr[11:7]).
we  input  1  write enable (RegWrite from the main control unit).
wd  input  WORDSIZE  write data from the writeback mux.
rd1  output  WORDSIZE  read data 1, to ALU in1.
rd2  output  WORDSIZE  read data 2, to ALU in2 / store data.

Behaviour:
- Storage: REGNUM entries of WORDSIZE bits. Entry 0 is not stored as a flop; it always reads 0.
- Reset:
  - Clock and reset: one clock (clk); reset (rst) is asynchronous and active-high.
  - rst high clears every entry to 0 immediately, without waiting for clk.
  - While rst is high, rd1 = rd2 = 0 for every index, and writes are ignored.
  - Deassertion is taken synchronously by the surrounding core. The first write is accepted on the first rising clk edge with rst low.
- Write:
  - On rising clk with we=1 and rd!=0, entry[rd] <= wd.
  - we=1 with rd=0 is a silent no-op: no state change, no error.
  - we=0 leaves all state unchanged.
- Read:
  - Purely combinational, zero latency: rd1 = (rs1==0) ? 0 : entry[rs1]; rd2 likewise for rs2.
  - Reads reflect the value held at the start of the cycle (old value), except as modified under Optional Feature.
- Simultaneous events:
  - rs1==rs2 gives both ports the same value.
  - Read and write of the same index in one cycle return the pre-write value unless bypass is enabled.
  - The write lands on the clock edge, so the value is visible on the following cycle.
- Width rules: no sign or zero extension. Data is stored and returned bit-exact; wd is never truncated.
- X handling: an rs1/rs2 containing X may produce X on that port only. It must not corrupt state.
- Reset mid-operation: asserting rst in the same cycle as a write drops the write. The entry reads 0 after reset.

Optional Feature:
Macro REGFILE_BYPASS_EN.
- Defined: write-through forwarding. If we=1, rd!=0 and rd==rs1, then rd1 = wd in the same cycle; same rule for rd2/rs2. This is a combinational path from wd to rd1/rd2. Used when the regfile is read in the second half of a cycle or in a pipelined variant. The bypass is suppressed while rst is high.
- Not defined: no forwarding; same-index read during a write returns the old value, as specified above.

Decomposition:
- Shared package/header (riscv_defs): `WORDSIZE, REGNUM, ADDRW, the X0 index constant (5'd0), and ABI index constants used by benches (RA=1, SP=2, A0=10).
- One natural sub-module: reg_file_rdport, which takes index, storage array view, and bypass inputs and returns read data with the x0 and bypass logic. It is instantiated twice, for rd1 and rd2.
- Write decode stays in reg_file.

Test Plan:
1. Reset: write 32'hDEADBEEF to x5, then pulse rst for 3 ns mid-cycle with no clk edge -> rd1 (rs1=5) = 0 immediately; all 32 indices read 0.
2. Basic write/read: we=1, rd=7, wd=32'h1234_5678; next cycle rs1=7, rs2=7 -> rd1 = rd2 = 32'h1234_5678. Other indices remain 0.
3. x0 protection: we=1, rd=0, wd=32'hFFFF_FFFF; next cycle rs1=0 -> rd1 = 0. No other register changes.
4. Same-cycle read/write of x3 (old value 32'hA, write 32'hB):
   - Without REGFILE_BYPASS_EN -> rd1 = 32'hA during the write cycle, 32'hB on the next cycle.
   - With REGFILE_BYPASS_EN -> rd1 = 32'hB during the write cycle.
5. Full sweep:
   - Write i*32'h0101_0101 to x1..x31 on consecutive cycles.
   - Read all pairs (rs1=i, rs2=31-i) -> exact values; index 0 reads 0.
   - Compare rd1 - rd2 against the ALU sub result (ctl=4'b0110).
6. we=0 with rd=9, wd=32'h5555_5555 -> x9 is unchanged (still holds 0x0909_0909 from the sweep).

Source files
------------

// File: rtl/reg_file_pkg.sv
// Shared constants for the RV32I integer register file.
// Optional write-through forwarding is selected by the REGFILE_BYPASS_EN macro.
package reg_file_pkg;

  localparam int RF_WORDSIZE = 32;
  localparam int RF_REGNUM   = 32;
  localparam int RF_ADDRW    = 5;

  typedef logic [RF_WORDSIZE-1:0] word_t;
  typedef logic [RF_ADDRW-1:0]    reg_idx_t;

  // ABI register indices
  localparam reg_idx_t X0 = 5'd0;
  localparam reg_idx_t RA = 5'd1;
  localparam reg_idx_t SP = 5'd2;
  localparam reg_idx_t A0 = 5'd10;

  localparam logic [3:0] ALU_SUB = 4'b0110;

endpackage

// File: rtl/reg_file_if.sv
// Register file access bundle: two read ports and one write port.
// The core drives through master; the register file receives through slave.
interface reg_file_if
  import reg_file_pkg::*;
#(
  parameter int WORDSIZE = RF_WORDSIZE,
  parameter int ADDRW    = RF_ADDRW
);

  logic [ADDRW-1:0]    rs1;
  logic [ADDRW-1:0]    rs2;
  logic [ADDRW-1:0]    rd;
  logic                we;
  logic [WORDSIZE-1:0] wd;
  logic [WORDSIZE-1:0] rd1;
  logic [WORDSIZE-1:0] rd2;

  modport master (output rs1, rs2, rd, we, wd, input rd1, rd2);
  modport slave  (input rs1, rs2, rd, we, wd, output rd1, rd2);

endinterface

// File: rtl/reg_file_rdport.sv
// Combinational read port: x0 forced to zero, with optional forwarding of
// the in-flight write when the parent asserts byp_en.
module reg_file_rdport
  import reg_file_pkg::*;
#(
  parameter int WORDSIZE = RF_WORDSIZE,
  parameter int REGNUM   = RF_REGNUM,
  parameter int ADDRW    = RF_ADDRW
) (
  input  logic [ADDRW-1:0]                idx,
  input  logic [REGNUM-1:0][WORDSIZE-1:0] regs_view,
  input  logic                            byp_en,
  input  logic [ADDRW-1:0]                byp_idx,
  input  logic [WORDSIZE-1:0]             byp_data,
  output logic [WORDSIZE-1:0]             data
);

  always_comb begin
    data = '0;
    if (idx != '0) begin
      data = regs_view[idx];
      if (byp_en && (byp_idx == idx)) data = byp_data;
    end
  end

endmodule

// File: rtl/reg_file.sv
// RV32I integer register file: two combinational reads, one synchronous write,
// x0 hardwired to zero. Define REGFILE_BYPASS_EN for write-through forwarding.
module reg_file
  import reg_file_pkg::*;
#(
  parameter int WORDSIZE = RF_WORDSIZE,
  parameter int REGNUM   = RF_REGNUM,
  parameter int ADDRW    = RF_ADDRW
) (
  input logic       clk,
  input logic       rst,
  reg_file_if.slave bus
);

  logic [WORDSIZE-1:0]             regs [1:REGNUM-1];
  logic [REGNUM-1:0][WORDSIZE-1:0] regs_view;
  logic                            byp_en;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 1; i < REGNUM; i++) regs[i] <= '0;
    end else if (bus.we && (bus.rd != '0)) begin
      regs[bus.rd] <= bus.wd;
    end
  end

  // Entry 0 has no storage; it appears as a constant zero in the read view.
  always_comb begin
    regs_view[0] = '0;
    for (int unsigned i = 1; i < REGNUM; i++) regs_view[i] = regs[i];
  end

`ifdef REGFILE_BYPASS_EN
  assign byp_en = bus.we && (bus.rd != '0) && !rst;
`else
  assign byp_en = 1'b0;
`endif

  reg_file_rdport #(.WORDSIZE(WORDSIZE), .REGNUM(REGNUM), .ADDRW(ADDRW)) u_rdport1 (
    .idx       (bus.rs1),
    .regs_view (regs_view),
    .byp_en    (byp_en),
    .byp_idx   (bus.rd),
    .byp_data  (bus.wd),
    .data      (bus.rd1)
  );

  reg_file_rdport #(.WORDSIZE(WORDSIZE), .REGNUM(REGNUM), .ADDRW(ADDRW)) u_rdport2 (
    .idx       (bus.rs2),
    .regs_view (regs_view),
    .byp_en    (byp_en),
    .byp_idx   (bus.rd),
    .byp_data  (bus.wd),
    .data      (bus.rd2)
  );

endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file against an array model of the registers.
// Follows REGFILE_BYPASS_EN for same-cycle read-during-write expectations.
module tb_reg_file;
  import reg_file_pkg::*;

  logic        clk;
  logic        rst;
  logic [31:0] model [32];
  int          n_cmp;
  int          n_err;

  reg_file_if rf ();

  reg_file dut (
    .clk (clk),
    .rst (rst),
    .bus (rf.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_read(input int idx, input logic r, input logic w_en,
                                           input int w_idx, input logic [31:0] w_data);
    if (r || idx == 0) return 32'h0;
`ifdef REGFILE_BYPASS_EN
    if (w_en && w_idx == idx) return w_data;
`endif
    return model[idx];
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
  endtask

  // One clock cycle: drive just after the rising edge, check at the falling edge.
  task automatic cycle(input string tag, input logic r, input logic [4:0] a1,
                       input logic [4:0] a2, input logic [4:0] w_idx,
                       input logic w_en, input logic [31:0] w_data);
    rst = r;
    rf.rs1 = a1;
    rf.rs2 = a2;
    rf.rd  = w_idx;
    rf.we  = w_en;
    rf.wd  = w_data;
    @(negedge clk);
    check({tag, "_rd1"}, rf.rd1, exp_read(int'(a1), r, w_en, int'(w_idx), w_data));
    check({tag, "_rd2"}, rf.rd2, exp_read(int'(a2), r, w_en, int'(w_idx), w_data));
    @(posedge clk);
    if (r) model_clear();
    else if (w_en && w_idx != 5'd0) model[w_idx] = w_data;
    #1;
  endtask

  initial begin
    logic [4:0]  a, b, w;
    logic [31:0] d;
    n_cmp = 0;
    n_err = 0;
    model_clear();
    rst = 1'b1;
    rf.rs1 = '0; rf.rs2 = '0; rf.rd = '0; rf.we = 1'b0; rf.wd = '0;

    // reset held across edges: writes ignored, reads zero
    cycle("rst_hold", 1'b1, 5'd5, 5'd6, 5'd5, 1'b1, 32'hDEADBEEF);
    cycle("rst_hold", 1'b1, 5'd5, 5'd5, 5'd5, 1'b1, 32'hDEADBEEF);

    // asynchronous reset pulse with no clock edge
    cycle("wr5", 1'b0, 5'd5, 5'd0, 5'd5, 1'b1, 32'hDEADBEEF);
    rf.we = 1'b0; rf.rs1 = 5'd5; rf.rs2 = 5'd5;
    #2;
    check("pre_rst", rf.rd1, 32'hDEADBEEF);
    rst = 1'b1;
    #1;
    check("async_rst_rd1", rf.rd1, 32'h0);
    check("async_rst_rd2", rf.rd2, 32'h0);
    #2;
    rst = 1'b0;
    #1;
    check("post_rst", rf.rd1, 32'h0);
    model_clear();
    @(posedge clk); #1;
    for (int i = 0; i < 32; i++) cycle("rst_sweep", 1'b0, 5'(i), 5'(31 - i), 5'd0, 1'b0, 32'h0);

    // write concurrent with reset is dropped, bypass suppressed
    cycle("rst_wr", 1'b1, 5'd6, 5'd6, 5'd6, 1'b1, 32'h6666_6666);
    cycle("rst_wr_after", 1'b0, 5'd6, 5'd6, 5'd0, 1'b0, 32'h0);

    // basic write/read
    cycle("wr7", 1'b0, 5'd0, 5'd0, 5'd7, 1'b1, 32'h1234_5678);
    cycle("rd7", 1'b0, 5'd7, 5'd7, 5'd0, 1'b0, 32'h0);
    check("x7_value", rf.rd1, 32'h1234_5678);
    cycle("rd_other", 1'b0, 5'd8, 5'd6, 5'd0, 1'b0, 32'h0);

    // x0 protection
    cycle("wr_x0", 1'b0, 5'd0, 5'd7, 5'd0, 1'b1, 32'hFFFF_FFFF);
    cycle("rd_x0", 1'b0, 5'd0, 5'd7, 5'd0, 1'b0, 32'h0);
    check("x0_zero", rf.rd1, 32'h0);

    // same-cycle read/write of x3
    cycle("wr3a", 1'b0, 5'd0, 5'd0, 5'd3, 1'b1, 32'hA);
    cycle("rw3", 1'b0, 5'd3, 5'd3, 5'd3, 1'b1, 32'hB);
    cycle("rd3b", 1'b0, 5'd3, 5'd0, 5'd0, 1'b0, 32'h0);
    check("x3_new", rf.rd1, 32'hB);

    // full sweep, then pairwise reads and ALU-style subtraction
    for (int i = 1; i < 32; i++)
      cycle("sweep_wr", 1'b0, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
            5'(i), 1'b1, 32'(i) * 32'h0101_0101);
    for (int i = 0; i < 32; i++) begin
      cycle("sweep_rd", 1'b0, 5'(i), 5'(31 - i), 5'd0, 1'b0, 32'h0);
      check("sub", rf.rd1 - rf.rd2, (32'(i) - 32'(31 - i)) * 32'h0101_0101);
    end

    // we=0 leaves x9 untouched
    cycle("we0", 1'b0, 5'd9, 5'd9, 5'd9, 1'b0, 32'h5555_5555);
    check("x9_hold", rf.rd1, 32'h0909_0909);

    cycle("abi", 1'b0, RA, SP, A0, 1'b1, 32'hCAFE_0A0A);
    cycle("abi_rd", 1'b0, A0, X0, 5'd0, 1'b0, 32'h0);

    // randomized traffic, biased toward same-index read/write and rare resets
    for (int n = 0; n < 400; n++) begin
      a = 5'($urandom_range(0, 31));
      b = 5'($urandom_range(0, 31));
      w = ($urandom_range(0, 3) == 0) ? a : 5'($urandom_range(0, 31));
      d = $urandom;
      cycle("rand", ($urandom_range(0, 40) == 0), a, b, w, 1'($urandom_range(0, 1)), d);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
